// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in enable ticks and reports high time, period and error flags.
module pwm_capture #(
    parameter int WIDTH_W    = 4,
    parameter int PERIOD_W   = 7,
    parameter int PERIOD_NOM = 80,
    parameter int PERIOD_TOL = 2,
    parameter int MAX_HIGH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    output logic [WIDTH_W-1:0]  width_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                valid,
    output logic                err_width,
    output logic                err_period,
    output logic                signal_lost
);
    typedef enum logic [1:0] {SEEK, ARMED, HIGH, LOW} state_e;

    localparam logic [WIDTH_W-1:0]  H_MAX = '1;
    localparam logic [WIDTH_W-1:0]  H_LIM = WIDTH_W'(MAX_HIGH);
    localparam logic [PERIOD_W-1:0] P_MAX = '1;
    localparam logic [PERIOD_W-1:0] P_LO  = PERIOD_W'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [PERIOD_W-1:0] P_HI  = PERIOD_W'(PERIOD_NOM + PERIOD_TOL);

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                prev_q, prev_d;
    logic [WIDTH_W-1:0]  hcnt_q, hcnt_d, width_q, width_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
    logic                valid_q, valid_d, ew_q, ew_d, ep_q, ep_d, lost_q, lost_d;
    logic                lvl, rise;

    assign lvl  = sync_q[1];
    assign rise = lvl & ~prev_q;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        hcnt_d   = hcnt_q;
        pcnt_d   = pcnt_q;
        width_d  = width_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ew_d     = ew_q;
        ep_d     = ep_q;
        lost_d   = lost_q;
        if (enable) begin
            prev_d = lvl;
            case (state_q)
                SEEK: state_d = lvl ? SEEK : ARMED;
                ARMED: if (rise) begin
                    hcnt_d  = 1;
                    pcnt_d  = 1;
                    state_d = HIGH;
                end
                default: if (rise) begin
                    width_d  = hcnt_q;
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    ew_d     = hcnt_q > H_LIM;
                    ep_d     = (pcnt_q < P_LO) || (pcnt_q > P_HI);
                    lost_d   = 1'b0;
                    hcnt_d   = 1;
                    pcnt_d   = 1;
                    state_d  = HIGH;
                end else if (pcnt_q == P_MAX - 1'b1) begin
                    // period counter reaching all-ones without a rise means the input is stuck
                    pcnt_d  = P_MAX;
                    lost_d  = 1'b1;
                    state_d = SEEK;
                end else begin
                    pcnt_d  = pcnt_q + 1'b1;
                    hcnt_d  = (lvl && hcnt_q != H_MAX) ? hcnt_q + 1'b1 : hcnt_q;
                    state_d = lvl ? HIGH : LOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            prev_q   <= 1'b1;
            state_q  <= SEEK;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            width_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ew_q     <= 1'b0;
            ep_q     <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], pwm_in};
            prev_q   <= prev_d;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            width_q  <= width_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ew_q     <= ew_d;
            ep_q     <= ep_d;
            lost_q   <= lost_d;
        end
    end

    assign width_out   = width_q;
    assign period_out  = period_q;
    assign valid       = valid_q;
    assign err_width   = ew_q;
    assign err_period  = ep_q;
    assign signal_lost = lost_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with hand-computed width/period/flag expectations.
module tb_pwm_capture;
    logic       clk = 1'b0;
    logic       reset, enable, pwm_in;
    logic [3:0] width_out;
    logic [6:0] period_out;
    logic       valid, err_width, err_period, signal_lost;
    int         vectors = 0, miscompares = 0;
    int         nv;
    logic       v0, lost_early;

    pwm_capture dut (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .width_out(width_out), .period_out(period_out), .valid(valid),
        .err_width(err_width), .err_period(err_period), .signal_lost(signal_lost)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one enable tick every 4 clk; the level is sampled on the tick's clock edge
    task automatic tick(input logic lv);
        pwm_in = lv;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic cyc(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            tick(i < h);
            if (i == 0) v0 = valid;
        end
    endtask

    task automatic res(input string tag, input int w, input int pd, input int ew, input int ep);
        check({tag, "_valid"}, v0, 1);
        check({tag, "_width"}, width_out, w);
        check({tag, "_period"}, period_out, pd);
        check({tag, "_err_width"}, err_width, ew);
        check({tag, "_err_period"}, err_period, ep);
    endtask

    task automatic zero_outs(input string tag);
        check({tag, "_width"}, width_out, 0);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_err_width"}, err_width, 0);
        check({tag, "_err_period"}, err_period, 0);
        check({tag, "_lost"}, signal_lost, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        zero_outs("reset");
        reset = 1'b0;
        repeat (4) tick(1'b0);
        cyc(6, 80);
        check("t1_first_rise_valid", v0, 0);
        cyc(6, 80);
        res("t1_rise2", 6, 80, 0, 0);
        cyc(6, 80);
        res("t1_rise3", 6, 80, 0, 0);
        cyc(12, 80);
        res("t1_rise4", 6, 80, 0, 0);
        cyc(20, 80);
        res("t2_high12", 12, 80, 1, 0);
        cyc(5, 78);
        res("t3_high20", 15, 80, 1, 0);
        cyc(5, 82);
        res("t4_p78", 5, 78, 0, 0);
        cyc(5, 77);
        res("t4_p82", 5, 82, 0, 0);
        cyc(5, 83);
        res("t4_p77", 5, 77, 0, 1);
        tick(1'b1);
        v0 = valid;
        res("t4_p83", 5, 83, 0, 1);
        nv = 0; lost_early = 1'b0;
        for (int i = 0; i < 125; i++) begin
            tick(1'b0);
            nv += int'(valid);
            lost_early |= signal_lost;
        end
        check("t5_lost_before_126", lost_early, 0);
        tick(1'b0);
        check("t5_lost_at_126", signal_lost, 1);
        check("t5_no_valid", nv + int'(valid), 0);
        check("t5_width_held", width_out, 5);
        repeat (10) tick(1'b0);
        check("t5_lost_holds", signal_lost, 1);
        cyc(6, 80);
        check("t5_rise1_valid", v0, 0);
        check("t5_rise1_lost", signal_lost, 1);
        cyc(6, 80);
        res("t5_rise2", 6, 80, 0, 0);
        check("t5_lost_cleared", signal_lost, 0);
        tick(1'b1);
        repeat (2) tick(1'b1);
        nv = 0;
        pwm_in = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            nv += int'(valid);
        end
        check("t6_gap_no_valid", nv, 0);
        repeat (3) tick(1'b1);
        repeat (74) tick(1'b0);
        tick(1'b1);
        v0 = valid;
        res("t6_gated", 6, 80, 0, 0);
        repeat (2) tick(1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        zero_outs("t6_reset");
        repeat (3) tick(1'b1);
        repeat (74) tick(1'b0);
        cyc(6, 80);
        check("t6_post_reset_rise1_valid", v0, 0);
        tick(1'b1);
        v0 = valid;
        res("t6_post_reset_rise2", 6, 80, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
